// File: rtl/spi_fpga_slave_sync.sv
// SPI slave clocked entirely by IN_CLOCK: SCLK/CS/MOSI are synchronized and
// edge-detected; a one-deep holding register feeds the transmit shifter.
module spi_fpga_slave_sync #(
   parameter int   PACK_LENGTH                = 8,
   parameter logic CPOL                       = 1'b0,
   parameter logic CPHA                       = 1'b1,
   parameter int   PACK_BIT_SEQUENCE_TRANSMIT = 1,
   parameter int   PACK_BIT_SEQUENCE_RECEIVE  = 1
) (
   input  logic                   IN_CLOCK,
   input  logic                   IN_RESET_N,
   input  logic [PACK_LENGTH-1:0] IN_TRANSMIT_DATA,
   input  logic                   IN_TRANSMIT_VALID,
   output logic                   OUT_TRANSMIT_READY,
   input  logic                   IN_SCLK,
   input  logic                   IN_CS,
   input  logic                   IN_MOSI,
   output logic                   OUT_MISO,
   output logic [PACK_LENGTH-1:0] OUT_RECEIVE_DATA,
   output logic                   OUT_RECEIVE_VALID,
   output logic                   OUT_BUSY
);

   localparam int   CW     = $clog2(PACK_LENGTH + 1);
   localparam logic TX_MSB = (PACK_BIT_SEQUENCE_TRANSMIT != 0);
   localparam logic RX_MSB = (PACK_BIT_SEQUENCE_RECEIVE != 0);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
   state_t state, state_nx;

   logic [1:0]             sclk_sync, cs_sync, mosi_sync, settle;
   logic                   sclk_prev, cs_prev, armed;
   logic                   sclk_s, cs_s, mosi_s;
   logic                   lead_edge, trail_edge, sample_edge, shift_edge, cs_fall;
   logic                   do_load, do_sample, do_shift, pack_done, handshake;
   logic [CW-1:0]          cnt;
   logic [PACK_LENGTH-1:0] hold_data, tx_sr, rx_sr, rx_next, load_word, rx_data_q;
   logic                   hold_full, miso_q, rx_valid_q;

   function automatic logic tx_bit(input logic [PACK_LENGTH-1:0] w);
      return TX_MSB ? w[PACK_LENGTH-1] : w[0];
   endfunction

   function automatic logic [PACK_LENGTH-1:0] tx_shift(input logic [PACK_LENGTH-1:0] w);
      return TX_MSB ? (w << 1) : (w >> 1);
   endfunction

   assign sclk_s = sclk_sync[1];
   assign cs_s   = cs_sync[1];
   assign mosi_s = mosi_sync[1];

   // armed blocks a false CS fall while the synchronizer flushes its reset value
   always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
      if (!IN_RESET_N) begin
         sclk_sync <= {2{CPOL}};
         cs_sync   <= 2'b11;
         mosi_sync <= 2'b00;
         sclk_prev <= CPOL;
         cs_prev   <= 1'b1;
         settle    <= 2'b00;
         armed     <= 1'b0;
      end else begin
         sclk_sync <= {sclk_sync[0], IN_SCLK};
         cs_sync   <= {cs_sync[0], IN_CS};
         mosi_sync <= {mosi_sync[0], IN_MOSI};
         sclk_prev <= sclk_s;
         cs_prev   <= cs_s;
         settle    <= {settle[0], 1'b1};
         armed     <= armed | (settle[1] & cs_s);
      end
   end

   assign lead_edge   = CPOL ? (sclk_prev & ~sclk_s) : (~sclk_prev & sclk_s);
   assign trail_edge  = CPOL ? (~sclk_prev & sclk_s) : (sclk_prev & ~sclk_s);
   assign sample_edge = CPHA ? trail_edge : lead_edge;
   assign shift_edge  = CPHA ? lead_edge : trail_edge;
   assign cs_fall     = armed & cs_prev & ~cs_s;

   // CPHA=0: the trailing edge right after the last sample belongs to the old pack
   assign do_load   = (state == LOAD) & ~cs_s;
   assign do_sample = (state == SHIFT) & ~cs_s & sample_edge;
   assign do_shift  = (state == SHIFT) & ~cs_s & shift_edge & (CPHA | (cnt != '0));
   assign pack_done = do_sample & (cnt == CW'(PACK_LENGTH - 1));
   assign handshake = IN_TRANSMIT_VALID & ~hold_full;
   assign load_word = handshake ? IN_TRANSMIT_DATA : (hold_full ? hold_data : '0);
   assign rx_next   = RX_MSB ? {rx_sr[PACK_LENGTH-2:0], mosi_s}
                             : {mosi_s, rx_sr[PACK_LENGTH-1:1]};

   always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
      if (!IN_RESET_N) state <= IDLE;
      else             state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (cs_fall) state_nx = LOAD;
         LOAD:    state_nx = SHIFT;
         SHIFT:   if (pack_done) state_nx = LOAD;
         default: state_nx = IDLE;
      endcase
      if (cs_s) state_nx = IDLE;
   end

   always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
      if (!IN_RESET_N) begin
         hold_full <= 1'b0;
         hold_data <= '0;
      end else if (do_load) begin
         hold_full <= 1'b0;
      end else if (handshake) begin
         hold_full <= 1'b1;
         hold_data <= IN_TRANSMIT_DATA;
      end
   end

   always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
      if (!IN_RESET_N) begin
         tx_sr  <= '0;
         miso_q <= 1'b0;
      end else if (state == IDLE) begin
         miso_q <= 1'b0;
      end else if (do_load) begin
         if (!CPHA) begin
            miso_q <= tx_bit(load_word);
            tx_sr  <= tx_shift(load_word);
         end else begin
            tx_sr  <= load_word;
         end
      end else if (do_shift) begin
         miso_q <= tx_bit(tx_sr);
         tx_sr  <= tx_shift(tx_sr);
      end
   end

   always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
      if (!IN_RESET_N) begin
         cnt        <= '0;
         rx_sr      <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
      end else begin
         rx_valid_q <= pack_done;
         if (pack_done) rx_data_q <= rx_next;
         if (cs_s || state == IDLE) begin
            cnt <= '0;
         end else if (do_sample) begin
            rx_sr <= rx_next;
            cnt   <= pack_done ? '0 : cnt + CW'(1);
         end
      end
   end

   assign OUT_TRANSMIT_READY = ~hold_full;
   assign OUT_MISO           = (state != IDLE) & miso_q;
   assign OUT_RECEIVE_DATA   = rx_data_q;
   assign OUT_RECEIVE_VALID  = rx_valid_q;
   assign OUT_BUSY           = (state != IDLE);

endmodule

// File: tb/tb_spi_fpga_slave_sync.sv
// Bench: five slaves (four CPOL/CPHA modes plus an LSB-first one) driven by a
// behavioural SPI master; expected words come from a simple queue model.
module tb_spi_fpga_slave_sync;

   localparam int N = 5;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sclk[N], cs[N], mosi[N], txv[N], miso[N], rdy[N], rxv[N], busy[N];
   logic [7:0] txd[N], rxd[N];

   int         n_chk = 0;
   int         n_err = 0;
   logic [7:0]  txq[$];
   logic [15:0] exp_rx[$];
   logic [15:0] rx_log[$];
   logic [7:0]  last_rx[N];

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      spi_fpga_slave_sync #(
         .PACK_LENGTH(8),
         .CPOL(g == 2 || g == 3 || g == 4),
         .CPHA(g == 1 || g == 3 || g == 4),
         .PACK_BIT_SEQUENCE_TRANSMIT(g == 4 ? 0 : 1),
         .PACK_BIT_SEQUENCE_RECEIVE(g == 4 ? 0 : 1)
      ) u_dut (
         .IN_CLOCK(clk),
         .IN_RESET_N(rst_n),
         .IN_TRANSMIT_DATA(txd[g]),
         .IN_TRANSMIT_VALID(txv[g]),
         .OUT_TRANSMIT_READY(rdy[g]),
         .IN_SCLK(sclk[g]),
         .IN_CS(cs[g]),
         .IN_MOSI(mosi[g]),
         .OUT_MISO(miso[g]),
         .OUT_RECEIVE_DATA(rxd[g]),
         .OUT_RECEIVE_VALID(rxv[g]),
         .OUT_BUSY(busy[g])
      );
   end

   function automatic logic cpol_of(input int k);
      return k >= 2;
   endfunction

   function automatic logic cpha_of(input int k);
      return (k == 1 || k == 3 || k == 4);
   endfunction

   function automatic logic lsb_of(input int k);
      return k == 4;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   always @(negedge clk) begin
      for (int k = 0; k < N; k++)
         if (rxv[k] === 1'b1) rx_log.push_back({8'(k), rxd[k]});
   end

   // SPI master, one bit per 8 IN_CLOCK cycles
   task automatic xfer(input int k, input logic [7:0] mo, input int nbits, output logic [7:0] mi);
      int b;
      mi = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         b = lsb_of(k) ? i : 7 - i;
         if (!cpha_of(k)) begin
            mosi[k] = mo[b];
            wait_clk(4);
            sclk[k] = ~cpol_of(k);
            mi[b]   = miso[k];
            wait_clk(4);
            sclk[k] = cpol_of(k);
         end else begin
            sclk[k] = ~cpol_of(k);
            mosi[k] = mo[b];
            wait_clk(4);
            sclk[k] = cpol_of(k);
            mi[b]   = miso[k];
            wait_clk(4);
         end
      end
   endtask

   task automatic push(input int k, input logic [7:0] w, input bit chk_rdy);
      int t = 0;
      txd[k] = w;
      txv[k] = 1'b1;
      while (rdy[k] !== 1'b1 && t < 2000) begin
         @(negedge clk);
         t++;
      end
      if (rdy[k] !== 1'b1) begin
         chk("push_timeout", rdy[k], 1);
         txv[k] = 1'b0;
      end else begin
         @(negedge clk);
         txv[k] = 1'b0;
         txq.push_back(w);
         if (chk_rdy) chk("rdy_drop", rdy[k], 0);
      end
   endtask

   task automatic pack(input int k, input logic [7:0] mo);
      logic [7:0] mi, exp_mi;
      exp_mi = (txq.size() > 0) ? txq.pop_front() : 8'h00;
      xfer(k, mo, 8, mi);
      chk($sformatf("miso_k%0d", k), mi, exp_mi);
      exp_rx.push_back({8'(k), mo});
      last_rx[k] = mo;
   endtask

   task automatic cs_low(input int k);
      cs[k] = 1'b0;
      wait_clk(4);
      chk("busy_set", busy[k], 1);
   endtask

   task automatic cs_high(input int k);
      wait_clk(4);
      cs[k] = 1'b1;
      wait_clk(6);
      chk("busy_clr", busy[k], 0);
      chk("miso_idle", miso[k], 0);
   endtask

   task automatic check_rx(input int k);
      int n;
      chk($sformatf("rx_count_k%0d", k), rx_log.size(), exp_rx.size());
      n = (rx_log.size() < exp_rx.size()) ? rx_log.size() : exp_rx.size();
      for (int i = 0; i < n; i++) chk("rx_data", rx_log[i], exp_rx[i]);
      chk("rx_hold", rxd[k], last_rx[k]);
      rx_log.delete();
      exp_rx.delete();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] mi;
      int k, npk;
      for (int i = 0; i < N; i++) begin
         sclk[i] = cpol_of(i);
         cs[i] = 1'b1;
         mosi[i] = 1'b0;
         txv[i] = 1'b0;
         txd[i] = 8'h00;
         last_rx[i] = 8'h00;
      end
      wait_clk(3);
      for (int i = 0; i < N; i++) begin
         chk("rst_busy", busy[i], 0);
         chk("rst_rdy", rdy[i], 1);
         chk("rst_miso", miso[i], 0);
         chk("rst_rxd", rxd[i], 0);
      end
      rst_n = 1'b1;
      wait_clk(4);

      // basic mode-1 transfer
      push(1, 8'h53, 1);
      cs_low(1);
      pack(1, 8'hEA);
      cs_high(1);
      check_rx(1);

      for (int m = 0; m < N; m++) begin
         push(m, 8'hA5, 1);
         cs_low(m);
         pack(m, 8'h3C);
         cs_high(m);
         check_rx(m);
      end

      // three packs under one CS, holding register refilled mid-frame
      for (int m = 0; m < 2; m++) begin
         push(m, 8'h11, 1);
         cs_low(m);
         fork
            begin
               pack(m, 8'($urandom));
               pack(m, 8'($urandom));
               pack(m, 8'($urandom));
            end
            begin
               push(m, 8'h22, 0);
               push(m, 8'h33, 0);
            end
         join
         cs_high(m);
         check_rx(m);
      end

      // empty holding register: zeros on MISO, RX still completes
      cs_low(2);
      pack(2, 8'($urandom));
      cs_high(2);
      check_rx(2);

      // CS raised after 5 bits
      cs_low(1);
      xfer(1, 8'($urandom), 5, mi);
      cs_high(1);
      check_rx(1);
      push(1, 8'($urandom), 1);
      cs_low(1);
      pack(1, 8'($urandom));
      cs_high(1);
      check_rx(1);

      for (int r = 0; r < 15; r++) begin
         k = int'($urandom_range(0, N - 1));
         npk = int'($urandom_range(1, 3));
         if ($urandom_range(0, 1) == 1) push(k, 8'($urandom), 1);
         cs_low(k);
         for (int p = 0; p < npk; p++) pack(k, 8'($urandom));
         cs_high(k);
         check_rx(k);
      end

      // reset mid-pack
      push(1, 8'h5A, 0);
      cs_low(1);
      xfer(1, 8'($urandom), 4, mi);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", busy[1], 0);
      chk("mid_rst_rdy", rdy[1], 1);
      chk("mid_rst_miso", miso[1], 0);
      chk("mid_rst_rxd", rxd[1], 0);
      chk("mid_rst_rxv", rxv[1], 0);
      txq.delete();
      for (int i = 0; i < N; i++) last_rx[i] = 8'h00;
      wait_clk(3);
      rst_n = 1'b1;
      wait_clk(10);
      chk("no_stale_fall", busy[1], 0);
      cs_high(1);
      push(1, 8'hC3, 1);
      cs_low(1);
      pack(1, 8'hC3);
      cs_high(1);
      check_rx(1);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/spi_fpga_slave_sync.md
SPI_FPGA_SLAVE_SYNC -- requirements
Module: spi_fpga_slave_sync

Interface
REQ-001 SHALL have parameter PACK_LENGTH, default 8: bits per pack.
REQ-002 SHALL have parameter CPOL, default 1'b0: SCLK idle level.
REQ-003 SHALL have parameter CPHA, default 1'b1: 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-004 SHALL have parameter PACK_BIT_SEQUENCE_TRANSMIT, default 1: 1 = MSB first, 0 = LSB first on MISO.
REQ-005 SHALL have parameter PACK_BIT_SEQUENCE_RECEIVE, default 1: 1 = MSB first, 0 = LSB first on MOSI.
REQ-006 SHALL have port IN_CLOCK, input, 1 bit: the single system clock; all logic uses its rising edge.
REQ-007 SHALL have port IN_RESET_N, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port IN_TRANSMIT_DATA, input, PACK_LENGTH bits: next pack to send.
REQ-009 SHALL have port IN_TRANSMIT_VALID, input, 1 bit: IN_TRANSMIT_DATA is valid.
REQ-010 SHALL have port OUT_TRANSMIT_READY, output, 1 bit: transmit holding register is empty.
REQ-011 SHALL have port IN_SCLK, input, 1 bit: SPI clock from the master, asynchronous to IN_CLOCK.
REQ-012 SHALL have port IN_CS, input, 1 bit: chip select, active low, asynchronous.
REQ-013 SHALL have port IN_MOSI, input, 1 bit: master-out data, asynchronous.
REQ-014 SHALL have port OUT_MISO, output, 1 bit: slave-out data.
REQ-015 SHALL have port OUT_RECEIVE_DATA, output, PACK_LENGTH bits: last complete received pack.
REQ-016 SHALL have port OUT_RECEIVE_VALID, output, 1 bit: one-cycle pulse when OUT_RECEIVE_DATA updates.
REQ-017 SHALL have port OUT_BUSY, output, 1 bit: high while the FSM is not in IDLE.

Function
REQ-018 SHALL pass IN_SCLK, IN_CS and IN_MOSI through 2-flop synchronizers and derive edges from the synchronized signals only.
REQ-019 SHALL define the leading edge as rising when CPOL = 0 and falling when CPOL = 1; the trailing edge is the opposite edge.
REQ-020 SHALL sample MOSI on the sample edge (leading if CPHA = 0, trailing if CPHA = 1) and shift MISO on the other edge.
REQ-021 SHALL require the SCLK frequency to be at most IN_CLOCK/8; faster SCLK behaviour is undefined.
REQ-022 SHALL use an FSM with states IDLE, LOAD and SHIFT: IDLE to LOAD on the synchronized CS falling edge; LOAD to SHIFT after 1 cycle; SHIFT to LOAD after PACK_LENGTH sample edges while CS is low; any state to IDLE on synchronized CS high.
REQ-023 In LOAD, SHALL copy the holding register into the TX shift register and mark the holding register empty; if it is empty, SHALL load all zeros.
REQ-024 SHALL load the holding register when IN_TRANSMIT_VALID and OUT_TRANSMIT_READY are both high; OUT_TRANSMIT_READY SHALL drop the next cycle.
REQ-025 If a handshake and a LOAD occur in the same cycle, SHALL forward the incoming data directly to the shift register and leave the holding register empty.
REQ-026 With CPHA = 0, SHALL present the first bit on OUT_MISO at the end of LOAD, before the first SCLK edge; with CPHA = 1, SHALL present the first bit on the first leading edge.
REQ-027 SHALL select the bit order with PACK_BIT_SEQUENCE_*: MSB first shifts left, LSB first shifts right.
REQ-028 SHALL drive OUT_MISO to 0 while in IDLE.
REQ-029 SHALL count sample edges with a $clog2(PACK_LENGTH+1)-bit counter; on the PACK_LENGTH-th edge it SHALL update OUT_RECEIVE_DATA and pulse OUT_RECEIVE_VALID 1 cycle later, then reset the counter.
REQ-030 SHALL support multi-pack frames: CS held low after PACK_LENGTH bits reloads through LOAD with no bit gap.
REQ-031 On CS rising mid-pack, SHALL discard the partial pack, leave OUT_RECEIVE_DATA unchanged, emit no pulse, clear the counter and enter IDLE; the holding register SHALL be retained.

Reset
REQ-032 While IN_RESET_N = 0, SHALL asynchronously force: FSM to IDLE, counter 0, shift registers 0, holding register empty, OUT_TRANSMIT_READY = 1, OUT_MISO = 0, OUT_RECEIVE_DATA = 0, OUT_RECEIVE_VALID = 0, OUT_BUSY = 0, synchronizer flops to CS = 1 and SCLK = CPOL.
REQ-033 Reset asserted mid-frame SHALL abort the pack; after release, the block SHALL wait for a fresh CS falling edge.

Verification
REQ-034 Test case: CPOL = 0, CPHA = 1, MSB first; slave sends 8'b01010011, master sends 8'b11101010 at IN_CLOCK/8. Expected: master receives 0x53, OUT_RECEIVE_DATA = 0xEA with exactly one VALID pulse.
REQ-035 Test case: all four CPOL/CPHA modes, slave sends 0xA5, master sends 0x3C. Expected: both ends receive correctly in every mode.
REQ-036 Test case: 3-pack frame with CS held low and TX fed 0x11, 0x22, 0x33 through the handshake. Expected: MISO carries 0x11, 0x22, 0x33; three VALID pulses.
REQ-037 Test case: holding register empty at frame start. Expected: MISO sends 0x00; RX still completes.
REQ-038 Test case: CS raised after 5 bits. Expected: no VALID pulse, OUT_RECEIVE_DATA unchanged, next full frame received correctly.
REQ-039 Test case: IN_RESET_N pulsed low mid-pack. Expected: outputs return to reset values immediately; next frame transfers 0xC3 correctly.
